// File: rtl/control_afisare_pkg.sv
// Shared types for the display sequencer: FSM state encoding and small decode helpers.
package control_afisare_pkg;

   typedef enum logic [1:0] {
      ST_STOP   = 2'd0,
      ST_RUN    = 2'd1,
      ST_TURN_L = 2'd2,
      ST_TURN_R = 2'd3
   } stare_t;

   function automatic logic is_turn(input stare_t s);
      return (s == ST_TURN_L) || (s == ST_TURN_R);
   endfunction

   // Desired mode from the synchronised {stanga, dreapta} line-sensor pair.
   function automatic stare_t target_from(input logic stanga, input logic dreapta);
      case ({stanga, dreapta})
         2'b10:   return ST_TURN_L;
         2'b01:   return ST_TURN_R;
         default: return ST_RUN;
      endcase
   endfunction

endpackage

// File: rtl/control_afisare_divizor_tick.sv
// Free-running modulo-DIV counter; tick is high while the count sits at its last value.
module divizor_tick #(
   parameter int DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset || clear)
         count <= '0;
      else if (count == LAST)
         count <= '0;
      else
         count <= count + W'(1);
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/control_afisare.sv
// Display sequencer: synchronises sensor/button/lap pins, runs the debounced mode FSM,
// blinks the turn indicators and keeps a BCD 00..99 lap count.
module control_afisare
   import control_afisare_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int BLINK_HZ   = 2,
   parameter int HOLD_CYC   = 5_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       senzor_stanga,
   input  logic       senzor_dreapta,
   input  logic       buton_stop,
   input  logic       puls_tur,
   input  logic       sterge_contor,
   output logic       tick_mux,
   output logic       stop,
   output logic       semnal_stanga,
   output logic       semnal_dreapta,
   output logic [3:0] cifra_zeci,
   output logic [3:0] cifra_unitati,
   output logic [1:0] stare
);

   localparam int DIV_MUX   = CLK_HZ / REFRESH_HZ;
   localparam int DIV_BLINK = CLK_HZ / (2 * BLINK_HZ);
   localparam int HW        = $clog2(HOLD_CYC + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

   // Pin order in the sync chain: {stanga, dreapta, buton, puls}.
   logic [3:0] sync1, sync2;
   logic       btn_prev, lap_prev;
   logic       btn_rise, lap_rise;

   stare_t          state_q, state_d, target, target_prev;
   logic [HW-1:0]   hold_q, hold_d;
   logic            blink_q, blink_tick, blink_clear, mux_tick;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1       <= '0;
         sync2       <= '0;
         btn_prev    <= 1'b0;
         lap_prev    <= 1'b0;
         target_prev <= ST_RUN;
      end else begin
         sync1       <= {senzor_stanga, senzor_dreapta, buton_stop, puls_tur};
         sync2       <= sync1;
         btn_prev    <= sync2[1];
         lap_prev    <= sync2[0];
         target_prev <= target;
      end
   end

   assign btn_rise = sync2[1] & ~btn_prev;
   assign lap_rise = sync2[0] & ~lap_prev;
   assign target   = target_from(sync2[3], sync2[2]);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_STOP;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // A changed pattern already counts its first stable cycle, so the mode
   // switches exactly HOLD_CYC cycles after the synchronised pattern appears.
   always_comb begin
      // NOTE: defaults first keep every path assigned, so no latch is inferred.
      state_d = state_q;
      hold_d  = hold_q;
      if (btn_rise) begin
         state_d = (state_q == ST_STOP) ? ST_RUN : ST_STOP;
         hold_d  = '0;
      end else if (state_q == ST_STOP || target == state_q) begin
         hold_d = '0;
      end else if (target != target_prev) begin
         hold_d = HW'(1);
      end else if (hold_q == HOLD_LAST) begin
         state_d = target;
         hold_d  = '0;
      end else begin
         hold_d = hold_q + HW'(1);
      end
   end

   divizor_tick #(.DIV(DIV_MUX)) u_div_mux (
      .clock (clock),
      .reset (reset),
      .clear (1'b0),
      .tick  (mux_tick)
   );

   assign blink_clear = (state_d != state_q) || !is_turn(state_q);

   divizor_tick #(.DIV(DIV_BLINK)) u_div_blink (
      .clock (clock),
      .reset (reset),
      .clear (blink_clear),
      .tick  (blink_tick)
   );

   always_ff @(posedge clock) begin
      if (reset)
         blink_q <= 1'b0;
      else if (state_d != state_q)
         blink_q <= is_turn(state_d);
      else if (!is_turn(state_q))
         blink_q <= 1'b0;
      else if (blink_tick)
         blink_q <= ~blink_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tick_mux       <= 1'b0;
         stop           <= 1'b1;
         semnal_stanga  <= 1'b0;
         semnal_dreapta <= 1'b0;
      end else begin
         tick_mux       <= mux_tick;
         stop           <= (state_q == ST_STOP);
         semnal_stanga  <= (state_q == ST_TURN_L) && blink_q;
         semnal_dreapta <= (state_q == ST_TURN_R) && blink_q;
      end
   end

   // Uses the pre-update state, so a lap edge arriving with the start press is not counted.
   always_ff @(posedge clock) begin
      if (reset || sterge_contor) begin
         cifra_zeci    <= 4'd0;
         cifra_unitati <= 4'd0;
      end else if (lap_rise && state_q != ST_STOP) begin
         if (cifra_unitati == 4'd9) begin
            cifra_unitati <= 4'd0;
            cifra_zeci    <= (cifra_zeci == 4'd9) ? 4'd0 : cifra_zeci + 4'd1;
         end else begin
            cifra_unitati <= cifra_unitati + 4'd1;
         end
      end
   end

   assign stare = state_q;

endmodule
